mux_scan: RTL and testbench
===========================

MUX_SCAN -- requirements
Module: mux_scan

Interface
REQ-001 Parameter N_CH, default 8: number of input channels, 2..64.
REQ-002 Parameter W, default 8: data width per channel, 1..32.
REQ-003 Parameter DWELL, default 4: cycles spent on each channel in scan mode, 1..255.
REQ-004 Port clk  input  1  sole clock, all state updates on its rising edge.
REQ-005 Port rst  input  1  synchronous, active-high reset.
REQ-006 Port din  input  N_CH*W  packed channel data; channel k occupies bits [k*W+W-1 : k*W].
REQ-007 Port sel  input  SW=max(1,$clog2(N_CH))  channel select, used in manual mode only.
REQ-008 Port mode  input  1  0 = manual, 1 = auto-scan.
REQ-009 Port ch_en  input  N_CH  per-channel enable mask, used in scan mode only.
REQ-010 Port y_ready  input  1  downstream accepts the output word.
REQ-011 Port y  output  W  registered selected data.
REQ-012 Port y_ch  output  SW  index of the channel that produced y.
REQ-013 Port y_valid  output  1  y/y_ch hold a word not yet accepted.

Function
REQ-014 Output slot is free in a cycle when y_valid==0 or y_ready==1; a capture loads y, y_ch and sets y_valid=1 at the next edge (latency 1 cycle from sampled din).
REQ-015 Accept = y_valid && y_ready; on accept with no simultaneous capture, y_valid clears; y/y_ch hold their last values.
REQ-016 While y_valid==1 && y_ready==0, y, y_ch and y_valid are held unchanged.
REQ-017 Manual mode: every cycle with slot free and sel<N_CH captures din channel sel with y_ch=sel.
REQ-018 Manual mode, sel>=N_CH: no capture; pending word behaves per REQ-015/016.
REQ-019 Scan FSM states: IDLE, DWELL, HOLD; internal pointer ptr (SW bits) and dwell counter cnt (8 bits).
REQ-020 In manual mode the FSM is forced to IDLE with cnt=0; ptr is retained.
REQ-021 IDLE, mode=1, ch_en!=0: ptr <= first enabled channel at or after ptr, searching upward with wrap; cnt<=0; next state DWELL.
REQ-022 IDLE, mode=1, ch_en==0: stay IDLE, no capture.
REQ-023 DWELL, cnt<DWELL-1: cnt<=cnt+1.
REQ-024 DWELL, cnt==DWELL-1, slot free: capture din channel ptr, y_ch=ptr; ptr <= next enabled channel after ptr (wrap modulo N_CH; ptr itself if it is the only one enabled); cnt<=0; stay DWELL.
REQ-025 DWELL, cnt==DWELL-1, slot not free: go HOLD, cnt held.
REQ-026 HOLD: capture per REQ-024 in the first cycle the slot is free, then return to DWELL; din is sampled in the capture cycle, not at HOLD entry.
REQ-027 DWELL or HOLD with ch_en[ptr]==0: no capture; ptr <= next enabled channel, cnt<=0, state DWELL; if ch_en==0, state IDLE.
REQ-028 mode 1->0 in any state: FSM to IDLE next edge; a pending output word is unaffected.
REQ-029 Capture and accept in the same cycle: new word loaded, y_valid remains 1.
REQ-030 DWELL=1: one capture per cycle while the slot stays free.

Reset
REQ-031 rst=1 at a clock edge: y=0, y_ch=0, y_valid=0, ptr=0, cnt=0, state IDLE; it overrides every other input, including mid-dwell or HOLD.
REQ-032 First capture after reset release: at the earliest in the cycle following release (manual) or DWELL+1 cycles after release (scan).

Verification (N_CH=8, W=8, DWELL=4)
REQ-033 Manual, y_ready=1, sel stepped 0..7 one per cycle, din channel k = 8'hA0+k -> y = A0..A7 one cycle late, y_ch matches, y_valid stays 1.
REQ-034 Scan, ch_en=8'b1000_0101, y_ready=1 -> y_ch sequence 0,2,7,0,... with one capture every 4 cycles.
REQ-035 Scan, y_ready=0 for 10 cycles after first capture -> y/y_ch frozen, FSM in HOLD; on y_ready=1 the next channel is captured the next edge.
REQ-036 Scan, clear ch_en[2] while ptr=2 mid-dwell -> channel 2 skipped, next capture is channel 7 after 4 full cycles; ch_en=0 -> IDLE, y_valid clears after accept.
REQ-037 Manual, sel=3'd5 with N_CH=6 variant and sel=6 -> no capture; rst asserted in HOLD -> all outputs 0 next edge.

Source files
------------

// File: rtl/mux_scan.sv
// Registered N-channel multiplexer with manual select and an auto-scan mode that
// dwells on each enabled channel before capturing it into a valid/ready output slot.
module mux_scan #(
  parameter  int N_CH  = 8,
  parameter  int W     = 8,
  parameter  int DWELL = 4,
  localparam int SW    = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_CH*W-1:0] din,
  input  logic [SW-1:0]     sel,
  input  logic              mode,
  input  logic [N_CH-1:0]   ch_en,
  input  logic              y_ready,
  output logic [W-1:0]      y,
  output logic [SW-1:0]     y_ch,
  output logic              y_valid
);

  typedef enum logic [1:0] {S_IDLE, S_DWELL, S_HOLD} state_t;

  localparam logic [7:0] CNT_LAST = 8'(DWELL - 1);

  state_t        state, state_nxt;
  logic [SW-1:0] ptr, ptr_nxt;
  logic [7:0]    cnt, cnt_nxt;
  logic          slot_free;
  logic          ptr_en;
  logic          capture;
  logic [SW-1:0] cap_ch;
  logic [W-1:0]  cap_data;

  // Upward search with wrap for the first enabled channel at or after start.
  function automatic logic [SW-1:0] first_en(input logic [N_CH-1:0] en, input int start);
    logic [SW-1:0] r;
    logic          found;
    int            idx;
    r     = SW'(start % N_CH);
    found = 1'b0;
    for (int i = 0; i < N_CH; i++) begin
      idx = (start + i) % N_CH;
      if (!found && en[idx]) begin
        r     = SW'(idx);
        found = 1'b1;
      end
    end
    return r;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      ptr   <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    cnt_nxt   = cnt;
    if (!mode) begin
      state_nxt = S_IDLE;
      cnt_nxt   = '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (|ch_en) begin
            ptr_nxt   = first_en(ch_en, int'(ptr));
            cnt_nxt   = '0;
            state_nxt = S_DWELL;
          end
        end
        default: begin
          // A channel disabled under the pointer is abandoned without capturing.
          if (!ptr_en) begin
            ptr_nxt   = first_en(ch_en, int'(ptr) + 1);
            cnt_nxt   = '0;
            state_nxt = (|ch_en) ? S_DWELL : S_IDLE;
          end else if (capture) begin
            ptr_nxt   = first_en(ch_en, int'(ptr) + 1);
            cnt_nxt   = '0;
            state_nxt = S_DWELL;
          end else if (state == S_DWELL) begin
            if (cnt == CNT_LAST) state_nxt = S_HOLD;
            else                 cnt_nxt   = cnt + 8'd1;
          end
        end
      endcase
    end
  end

  always_comb begin
    slot_free = !y_valid || y_ready;
    ptr_en    = |(ch_en & (N_CH'(1) << ptr));
    capture   = 1'b0;
    cap_ch    = ptr;
    if (!mode) begin
      if (int'(sel) < N_CH) begin
        cap_ch  = sel;
        capture = slot_free;
      end
    end else if (((state == S_DWELL && cnt == CNT_LAST) || state == S_HOLD) && ptr_en) begin
      capture = slot_free;
    end
    cap_data = din[int'(cap_ch)*W +: W];
  end

  // A capture wins over a same-cycle accept, so the slot stays valid with the new word.
  always_ff @(posedge clk) begin
    if (rst) begin
      y       <= '0;
      y_ch    <= '0;
      y_valid <= 1'b0;
    end else if (capture) begin
      y       <= cap_data;
      y_ch    <= cap_ch;
      y_valid <= 1'b1;
    end else if (y_valid && y_ready) begin
      y_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mux_scan.sv
// Scoreboard bench for mux_scan: expected words are queued with their accept cycle
// and a negedge monitor pops and compares them; a 6-channel DWELL=1 copy covers edge cases.
module tb_mux_scan;

  typedef struct {
    int cyc;
    int ch;
    int data;
  } exp_t;

  logic        clk;
  logic        rst;
  logic [63:0] din;
  logic [2:0]  sel;
  logic        mode;
  logic [7:0]  ch_en;
  logic        y_ready;
  logic [7:0]  y;
  logic [2:0]  y_ch;
  logic        y_valid;

  logic [47:0] din6;
  logic [2:0]  sel6;
  logic        mode6;
  logic [5:0]  ch_en6;
  logic        y_ready6;
  logic [7:0]  y6;
  logic [2:0]  y_ch6;
  logic        y_valid6;

  int          cyc = 0;
  int          n_tests = 0;
  int          n_fail = 0;
  exp_t        sb[$];
  exp_t        mon_e;
  string       chk_name[$];
  logic [31:0] chk_act[$];
  logic [31:0] chk_exp[$];
  string       mon_nm;
  logic [31:0] mon_act;
  logic [31:0] mon_exp;
  int          r;
  int          exp6[4] = '{0, 2, 5, 0};

  mux_scan #(.N_CH(8), .W(8), .DWELL(4)) dut (
    .clk(clk), .rst(rst), .din(din), .sel(sel), .mode(mode), .ch_en(ch_en),
    .y_ready(y_ready), .y(y), .y_ch(y_ch), .y_valid(y_valid)
  );

  mux_scan #(.N_CH(6), .W(8), .DWELL(1)) dut6 (
    .clk(clk), .rst(rst), .din(din6), .sel(sel6), .mode(mode6), .ch_en(ch_en6),
    .y_ready(y_ready6), .y(y6), .y_ch(y_ch6), .y_valid(y_valid6)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Sole owner of the counters: drains direct checks, then scores accepted words.
  always @(negedge clk) begin
    while (chk_name.size() > 0) begin
      mon_nm  = chk_name.pop_front();
      mon_act = chk_act.pop_front();
      mon_exp = chk_exp.pop_front();
      n_tests++;
      if (mon_act !== mon_exp) begin
        n_fail++;
        $display("[TB] FAIL %s: got %0h, required %0h", mon_nm, mon_act, mon_exp);
      end
    end
    if (!rst && y_valid && y_ready) begin
      n_tests++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("[TB] FAIL unexpected_word: got ch %0d data %0h at cycle %0d, required no word",
                 y_ch, y, cyc);
      end else begin
        mon_e = sb.pop_front();
        if (mon_e.cyc != cyc || y_ch !== 3'(mon_e.ch) || y !== 8'(mon_e.data)) begin
          n_fail++;
          $display("[TB] FAIL scoreboard_word: got ch %0d data %0h cycle %0d, required ch %0d data %0h cycle %0d",
                   y_ch, y, cyc, mon_e.ch, mon_e.data, mon_e.cyc);
        end
      end
    end
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_name.push_back(name);
    chk_act.push_back(act);
    chk_exp.push_back(exp);
  endtask

  task automatic expect_word(input int at, input int ch, input int data);
    exp_t e;
    e.cyc  = at;
    e.ch   = ch;
    e.data = data;
    sb.push_back(e);
  endtask

  task automatic set_din(input logic [7:0] base);
    for (int k = 0; k < 8; k++) din[k*8 +: 8] = base + 8'(k);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(2);
    check_output("reset_y", 32'(y), 32'h0);
    check_output("reset_y_ch", 32'(y_ch), 32'h0);
    check_output("reset_y_valid", 32'(y_valid), 32'h0);
    rst = 1'b0;
    r   = cyc;
  endtask

  task automatic apply_stimulus();
    // Reset overrides a manual select that would otherwise capture.
    do_reset();

    // Manual sweep: each select appears one cycle later, back to back.
    for (int k = 0; k < 8; k++) begin
      sel = 3'(k);
      expect_word(cyc + 1, k, 8'hA0 + k);
      step();
    end
    mode  = 1'b1;
    ch_en = 8'h00;
    step(2);
    check_output("manual_drain_valid", 32'(y_valid), 32'h0);
    check_output("manual_hold_y", 32'(y), 32'hA7);
    check_output("manual_hold_y_ch", 32'(y_ch), 32'h7);

    // Scan 0,2,7,0,2 every DWELL cycles.
    do_reset();
    set_din(8'h30);
    mode    = 1'b1;
    ch_en   = 8'b1000_0101;
    y_ready = 1'b1;
    expect_word(r + 5, 0, 8'h30);
    expect_word(r + 9, 2, 8'h32);
    expect_word(r + 13, 7, 8'h37);
    expect_word(r + 17, 0, 8'h30);
    expect_word(r + 21, 2, 8'h32);
    step(4);
    check_output("scan_no_early_capture", 32'(y_valid), 32'h0);
    step(19);

    // Backpressure after first capture: word frozen, next channel sampled on release.
    do_reset();
    step(5);
    y_ready = 1'b0;
    expect_word(r + 15, 0, 8'h30);
    step(5);
    check_output("hold_y_ch", 32'(y_ch), 32'h0);
    check_output("hold_y", 32'(y), 32'h30);
    check_output("hold_y_valid", 32'(y_valid), 32'h1);
    set_din(8'h50);
    step(5);
    y_ready = 1'b1;
    expect_word(r + 16, 2, 8'h52);
    expect_word(r + 20, 7, 8'h57);
    step(6);

    // Disable channel 2 mid-dwell, then disable everything.
    do_reset();
    set_din(8'h30);
    ch_en = 8'b1000_0101;
    expect_word(r + 5, 0, 8'h30);
    expect_word(r + 12, 7, 8'h37);
    expect_word(r + 18, 0, 8'h30);
    step(7);
    ch_en = 8'b1000_0001;
    step(9);
    y_ready = 1'b0;
    ch_en   = 8'h00;
    step(2);
    y_ready = 1'b1;
    step(2);
    check_output("idle_valid_cleared", 32'(y_valid), 32'h0);
    check_output("idle_y_ch_held", 32'(y_ch), 32'h0);
    check_output("idle_y_held", 32'(y), 32'h30);
    step(6);

    // Reset while in HOLD, then a single enabled channel recaptures itself.
    y_ready = 1'b0;
    ch_en   = 8'b1000_0101;
    do_reset();
    step(8);
    check_output("pre_reset_valid", 32'(y_valid), 32'h1);
    check_output("pre_reset_y_ch", 32'(y_ch), 32'h0);
    step(3);
    rst = 1'b1;
    step();
    check_output("hold_reset_y", 32'(y), 32'h0);
    check_output("hold_reset_y_ch", 32'(y_ch), 32'h0);
    check_output("hold_reset_valid", 32'(y_valid), 32'h0);
    rst     = 1'b0;
    r       = cyc;
    y_ready = 1'b1;
    ch_en   = 8'b0000_0100;
    expect_word(r + 5, 2, 8'h32);
    expect_word(r + 9, 2, 8'h32);
    step(10);

    // Six-channel, DWELL=1 copy: out-of-range select and one capture per cycle.
    ch_en = 8'h00;
    do_reset();
    sel6 = 3'd5;
    step();
    check_output("n6_sel5_y", 32'(y6), 32'h65);
    check_output("n6_sel5_y_ch", 32'(y_ch6), 32'h5);
    check_output("n6_sel5_valid", 32'(y_valid6), 32'h1);
    sel6 = 3'd6;
    step();
    check_output("n6_sel6_no_capture", 32'(y_valid6), 32'h0);
    check_output("n6_sel6_y_ch_held", 32'(y_ch6), 32'h5);
    mode6  = 1'b1;
    ch_en6 = 6'b10_0101;
    step();
    for (int k = 0; k < 4; k++) begin
      step();
      check_output("n6_dwell1_y_ch", 32'(y_ch6), 32'(exp6[k]));
      check_output("n6_dwell1_y", 32'(y6), 32'h60 + 32'(exp6[k]));
      check_output("n6_dwell1_valid", 32'(y_valid6), 32'h1);
    end
  endtask

  initial begin
    rst      = 1'b1;
    set_din(8'hA0);
    sel      = 3'd3;
    mode     = 1'b0;
    ch_en    = 8'h00;
    y_ready  = 1'b1;
    for (int k = 0; k < 6; k++) din6[k*8 +: 8] = 8'h60 + 8'(k);
    sel6     = 3'd7;
    mode6    = 1'b0;
    ch_en6   = 6'h00;
    y_ready6 = 1'b1;

    apply_stimulus();

    check_output("scoreboard_drained", 32'(sb.size()), 32'h0);
    step(2);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
